// File: rtl/multicycle_divider_if.sv
// Request/response bundle for the iterative divider.
// master drives operands and out_ready; slave answers with in_ready and results.
interface multicycle_divider_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  Signed;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Quotient;
    logic [DATA_WIDTH-1:0] Remainder;
    logic                  DivByZero;

    modport master (
        output in_valid, A, B, Signed, out_ready,
        input  in_ready, out_valid, Quotient, Remainder, DivByZero
    );

    modport slave (
        input  in_valid, A, B, Signed, out_ready,
        output in_ready, out_valid, Quotient, Remainder, DivByZero
    );
endinterface

// File: rtl/multicycle_divider.sv
// Restoring divider for DIV/DIVU, one quotient bit per cycle.
// Ports: clk, rst (async, active-high), bus (slave: operands in, LO/HI out).
module multicycle_divider #(
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_divider_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic           sa_q, sa_d;
    logic           sb_q, sb_d;
    logic           dbz_q, dbz_d;
    logic [W-1:0]   q_res_q, q_res_d;
    logic [W-1:0]   r_res_q, r_res_d;
    logic           dz_res_q, dz_res_d;

    logic [W:0]     shifted;
    logic           borrow;
    logic [W-1:0]   rem_n;
    logic [W-1:0]   quo_n;
    logic [W-1:0]   q_fix;
    logic [W-1:0]   r_fix;
    logic           last;
    logic           a_neg;
    logic           b_neg;

    // One extra bit on the shifted remainder keeps |most-negative| exact.
    assign shifted = {rem_q, quo_q[W-1]};
    assign borrow  = shifted < {1'b0, dvs_q};
    // Remainder after a successful subtract is below the divisor, so W bits suffice.
    assign rem_n   = borrow ? shifted[W-1:0] : shifted[W-1:0] - dvs_q;
    assign quo_n   = {quo_q[W-2:0], ~borrow};
    assign last    = (cnt_q == CW'(W - 1));

    // sa_q/sb_q are only set for signed ops, so they gate correction alone.
    // A zero divisor leaves rem = |A|, so sign fixup restores the original A.
    assign q_fix = dbz_q ? '1 : ((sa_q ^ sb_q) ? -quo_n : quo_n);
    assign r_fix = sa_q ? -rem_n : rem_n;

    assign a_neg = bus.Signed & bus.A[W-1];
    assign b_neg = bus.Signed & bus.B[W-1];

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Quotient  = q_res_q;
    assign bus.Remainder = r_res_q;
    assign bus.DivByZero = dz_res_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dbz_q    <= 1'b0;
            q_res_q  <= '0;
            r_res_q  <= '0;
            dz_res_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dbz_q    <= dbz_d;
            q_res_q  <= q_res_d;
            r_res_q  <= r_res_d;
            dz_res_q <= dz_res_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dbz_d    = dbz_q;
        q_res_d  = q_res_q;
        r_res_d  = r_res_q;
        dz_res_d = dz_res_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    quo_d   = a_neg ? -bus.A : bus.A;
                    dvs_d   = b_neg ? -bus.B : bus.B;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    dbz_d   = (bus.B == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    q_res_d  = q_fix;
                    r_res_d  = r_fix;
                    dz_res_d = dbz_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_multicycle_divider.sv
// Self-checking bench for multicycle_divider.
// Directed table, random ops vs arithmetic model, backpressure and reset cases.
module tb_multicycle_divider;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_divider_if #(.DATA_WIDTH(32)) dif ();

    multicycle_divider #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q,
                                  output logic [31:0] r, output logic dz);
        longint sa, sb;
        if (b == 0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Present a request and return just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        int n;
        @(negedge clk);
        dif.A        = a;
        dif.B        = b;
        dif.Signed   = s;
        dif.in_valid = 1'b1;
        n = 0;
        while (!dif.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(dif.in_ready), 64'd1);
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid is seen at a negedge.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!dif.out_valid && lat < 100);
    endtask

    task automatic consume(input string name);
        @(negedge clk);
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_ov_drop"}, 64'(dif.out_valid), 64'd0);
        chk({name, "_idle"}, 64'(dif.in_ready), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] a,
                          input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz);
        int lat;
        issue(a, b, s);
        wait_done(lat);
        chk({name, "_lat"}, 64'(lat), 64'd32);
        chk({name, "_q"}, 64'(dif.Quotient), 64'(eq));
        chk({name, "_r"}, 64'(dif.Remainder), 64'(er));
        chk({name, "_dz"}, 64'(dif.DivByZero), 64'(edz));
        consume(name);
    endtask

    vec_t vt[10];

    initial begin
        logic [31:0] a, b, q0, r0, eq, er;
        logic        s, edz, seen;
        int          lat;

        vt[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0};
        vt[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vt[2] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0};
        vt[3] = '{32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        vt[4] = '{32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        vt[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0};
        vt[6] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vt[7] = '{32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 1'b0};
        vt[8] = '{32'hFFFF_FFFD, 32'd10, 1'b1, 32'd0, 32'hFFFF_FFFD, 1'b0};
        vt[9] = '{32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1};

        rst           = 1'b1;
        dif.in_valid  = 1'b0;
        dif.A         = '0;
        dif.B         = '0;
        dif.Signed    = 1'b0;
        dif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(dif.in_ready), 64'd1);
        chk("rst_out_valid", 64'(dif.out_valid), 64'd0);
        chk("rst_q", 64'(dif.Quotient), 64'd0);
        chk("rst_r", 64'(dif.Remainder), 64'd0);
        chk("rst_dz", 64'(dif.DivByZero), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].s,
                   vt[i].q, vt[i].r, vt[i].dz);
        end

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            model(a, b, s, eq, er, edz);
            run_op($sformatf("rnd%0d", i), a, b, s, eq, er, edz);
        end

        // Backpressure: result must hold and stray requests must be ignored.
        issue(32'd50, 32'd6, 1'b0);
        wait_done(lat);
        chk("bp_lat", 64'(lat), 64'd32);
        chk("bp_q", 64'(dif.Quotient), 64'd8);
        chk("bp_r", 64'(dif.Remainder), 64'd2);
        q0 = dif.Quotient;
        r0 = dif.Remainder;
        dif.A        = 32'd999;
        dif.B        = 32'd4;
        dif.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_q", 64'(dif.Quotient), 64'(q0));
            chk("bp_hold_r", 64'(dif.Remainder), 64'(r0));
            chk("bp_hold_ov", 64'(dif.out_valid), 64'd1);
            chk("bp_hold_ir", 64'(dif.in_ready), 64'd0);
        end
        dif.A         = 32'd1000;
        dif.B         = 32'd9;
        dif.Signed    = 1'b0;
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1 dif.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle", 64'(dif.in_ready), 64'd1);
        chk("bp_ov_drop", 64'(dif.out_valid), 64'd0);
        chk("bp_keep_q", 64'(dif.Quotient), 64'd8);
        @(posedge clk);
        #1 dif.in_valid = 1'b0;
        wait_done(lat);
        chk("b2b_lat", 64'(lat), 64'd32);
        chk("b2b_q", 64'(dif.Quotient), 64'd111);
        chk("b2b_r", 64'(dif.Remainder), 64'd1);
        consume("b2b");

        // Asynchronous reset in the middle of an iteration run.
        issue(32'd12345, 32'd67, 1'b0);
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ir", 64'(dif.in_ready), 64'd1);
        chk("mid_rst_ov", 64'(dif.out_valid), 64'd0);
        chk("mid_rst_q", 64'(dif.Quotient), 64'd0);
        chk("mid_rst_r", 64'(dif.Remainder), 64'd0);
        chk("mid_rst_dz", 64'(dif.DivByZero), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (dif.out_valid) seen = 1'b1;
        end
        chk("mid_rst_dropped", 64'(seen), 64'd0);
        run_op("post_rst", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
